// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding logic of the 5-stage pipeline.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/forwarding_select.sv
// EX-stage operand source select for one operand; MEM result beats WB result, x0 never forwarded.
module forwarding_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_SIZE = 5
) (
  input  logic [REG_ADDR_SIZE-1:0] rs,
  input  logic [REG_ADDR_SIZE-1:0] mem_rd,
  input  logic [REG_ADDR_SIZE-1:0] wb_rd,
  input  logic                     mem_reg_write,
  input  logic                     wb_reg_write,
  output logic [1:0]               sel
);

  fwd_sel_t sel_e;

  always_comb begin
    sel_e = FWD_REG;
    if (mem_reg_write && mem_rd != REG_ADDR_SIZE'(REG_ZERO) && mem_rd == rs) begin
      sel_e = FWD_MEM;
    end else if (wb_reg_write && wb_rd != REG_ADDR_SIZE'(REG_ZERO) && wb_rd == rs) begin
      sel_e = FWD_WB;
    end
  end

  assign sel = sel_e;

endmodule

// File: rtl/hazard_forwarding_unit.sv
// Load-use stall FSM, taken-branch flush sequencer, saturating perf counters and EX forwarding.
// PIPELINED_FORWARDING_EN enables forwarding; without it any in-flight producer stalls ID.
module hazard_forwarding_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_SIZE = 5,
  parameter int LOAD_LATENCY  = 1,
  parameter int CNT_SIZE      = 16
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [REG_ADDR_SIZE-1:0] id_rs1,
  input  logic [REG_ADDR_SIZE-1:0] id_rs2,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic [REG_ADDR_SIZE-1:0] ex_rs1,
  input  logic [REG_ADDR_SIZE-1:0] ex_rs2,
  input  logic [REG_ADDR_SIZE-1:0] ex_rd,
  input  logic [REG_ADDR_SIZE-1:0] mem_rd,
  input  logic [REG_ADDR_SIZE-1:0] wb_rd,
  input  logic                     ex_reg_write,
  input  logic                     mem_reg_write,
  input  logic                     wb_reg_write,
  input  logic                     ex_mem_read,
  input  logic                     branch_taken_mem,
  output logic                     pc_hold,
  output logic                     if_id_hold,
  output logic                     if_id_clear,
  output logic                     id_ex_clear,
  output logic                     ex_mem_clear,
  output logic [1:0]               fwd_a_sel,
  output logic [1:0]               fwd_b_sel,
  output logic [CNT_SIZE-1:0]      stall_count,
  output logic [CNT_SIZE-1:0]      flush_count,
  output logic                     busy
);

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LATENCY - 1);

  function automatic logic src_hit(
    input logic                     we,
    input logic [REG_ADDR_SIZE-1:0] rd,
    input logic [REG_ADDR_SIZE-1:0] rs1,
    input logic [REG_ADDR_SIZE-1:0] rs2,
    input logic                     use1,
    input logic                     use2
  );
    return we && rd != REG_ADDR_SIZE'(REG_ZERO) &&
           ((use1 && rs1 == rd) || (use2 && rs2 == rd));
  endfunction

  hz_state_t  state, state_nxt;
  logic [2:0] bub_cnt, bub_cnt_nxt;
  logic       hz, bubble, hit_ex;

  assign hit_ex = src_hit(ex_reg_write, ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2);

`ifdef PIPELINED_FORWARDING_EN
  localparam bit MULTI = (LOAD_LATENCY > 1);

  assign hz = ex_mem_read && hit_ex;

  forwarding_select #(.REG_ADDR_SIZE(REG_ADDR_SIZE)) u_fwd_a (
    .rs(ex_rs1), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .sel(fwd_a_sel)
  );

  forwarding_select #(.REG_ADDR_SIZE(REG_ADDR_SIZE)) u_fwd_b (
    .rs(ex_rs2), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .sel(fwd_b_sel)
  );
`else
  // No bypass network: stall re-evaluates every cycle until no producer is in flight.
  localparam bit MULTI = 1'b0;

  logic hit_mem, hit_wb, unused_no_fwd;

  assign hit_mem = src_hit(mem_reg_write, mem_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2);
  assign hit_wb  = src_hit(wb_reg_write, wb_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2);
  assign hz      = hit_ex || hit_mem || hit_wb;

  assign fwd_a_sel     = 2'd0;
  assign fwd_b_sel     = 2'd0;
  assign unused_no_fwd = ^{ex_rs1, ex_rs2, ex_mem_read};
`endif

  always_comb begin
    state_nxt    = state;
    bub_cnt_nxt  = bub_cnt;
    bubble       = 1'b0;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_clear  = 1'b0;
    id_ex_clear  = 1'b0;
    ex_mem_clear = 1'b0;
    if (branch_taken_mem) begin
      // Flush wins over any stall; PC is left free to load the branch target.
      if_id_clear  = 1'b1;
      id_ex_clear  = 1'b1;
      ex_mem_clear = 1'b1;
      state_nxt    = FLUSH;
      bub_cnt_nxt  = 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (hz) begin
            bubble = 1'b1;
            if (MULTI) begin
              state_nxt   = STALL;
              bub_cnt_nxt = LAT_M1;
            end
          end
        end
        STALL: begin
          bubble      = 1'b1;
          bub_cnt_nxt = bub_cnt - 3'd1;
          if (bub_cnt == 3'd1) state_nxt = RUN;
        end
        FLUSH:   state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
      pc_hold     = bubble;
      if_id_hold  = bubble;
      id_ex_clear = bubble;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state       <= RUN;
      bub_cnt     <= 3'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_cnt_nxt;
      if (bubble && stall_count != '1) stall_count <= stall_count + CNT_SIZE'(1);
      if (branch_taken_mem && flush_count != '1) flush_count <= flush_count + CNT_SIZE'(1);
    end
  end

  assign busy = (state != RUN);

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Bench for hazard_forwarding_unit: LOAD_LATENCY=1/CNT_SIZE=16 and LOAD_LATENCY=3/CNT_SIZE=4 side by side.
module tb_hazard_forwarding_unit;

`ifdef PIPELINED_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic        pc_hold;
    logic        if_id_hold;
    logic        if_id_clear;
    logic        id_ex_clear;
    logic        ex_mem_clear;
    logic        busy;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] sc;
    logic [15:0] fc;
  } obs_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESET_N;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_reg_write, mem_reg_write, wb_reg_write;
  logic       ex_mem_read, branch_taken_mem;

  logic        pc_hold_0, if_id_hold_0, if_id_clear_0, id_ex_clear_0, ex_mem_clear_0, busy_0;
  logic [1:0]  fa_0, fb_0;
  logic [15:0] sc_0, fc_0;
  logic        pc_hold_1, if_id_hold_1, if_id_clear_1, id_ex_clear_1, ex_mem_clear_1, busy_1;
  logic [1:0]  fa_1, fb_1;
  logic [3:0]  sc_1, fc_1;

  hazard_forwarding_unit #(.REG_ADDR_SIZE(5), .LOAD_LATENCY(1), .CNT_SIZE(16)) u_d1 (
    .CLK(CLK), .RESET_N(RESET_N),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_mem_read(ex_mem_read), .branch_taken_mem(branch_taken_mem),
    .pc_hold(pc_hold_0), .if_id_hold(if_id_hold_0), .if_id_clear(if_id_clear_0),
    .id_ex_clear(id_ex_clear_0), .ex_mem_clear(ex_mem_clear_0),
    .fwd_a_sel(fa_0), .fwd_b_sel(fb_0), .stall_count(sc_0), .flush_count(fc_0), .busy(busy_0)
  );

  hazard_forwarding_unit #(.REG_ADDR_SIZE(5), .LOAD_LATENCY(3), .CNT_SIZE(4)) u_d3 (
    .CLK(CLK), .RESET_N(RESET_N),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_mem_read(ex_mem_read), .branch_taken_mem(branch_taken_mem),
    .pc_hold(pc_hold_1), .if_id_hold(if_id_hold_1), .if_id_clear(if_id_clear_1),
    .id_ex_clear(id_ex_clear_1), .ex_mem_clear(ex_mem_clear_1),
    .fwd_a_sel(fa_1), .fwd_b_sel(fb_1), .stall_count(sc_1), .flush_count(fc_1), .busy(busy_1)
  );

  obs_t obs0, obs1;
  assign obs0 = {pc_hold_0, if_id_hold_0, if_id_clear_0, id_ex_clear_0, ex_mem_clear_0, busy_0,
                 fa_0, fb_0, sc_0, fc_0};
  assign obs1 = {pc_hold_1, if_id_hold_1, if_id_clear_1, id_ex_clear_1, ex_mem_clear_1, busy_1,
                 fa_1, fb_1, 12'd0, sc_1, 12'd0, fc_1};

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: bubbles still owed after this cycle, flush-cycle flag, counter values.
  int lat  [2] = '{1, 3};
  int cmax [2] = '{65535, 15};
  int left [2] = '{0, 0};
  int nleft[2] = '{0, 0};
  bit fl   [2] = '{0, 0};
  bit nfl  [2] = '{0, 0};
  int sc   [2] = '{0, 0};
  int nsc  [2] = '{0, 0};
  int fc   [2] = '{0, 0};
  int nfc  [2] = '{0, 0};

  function automatic bit src_match(input logic [4:0] rd, input logic we);
    return we && rd != 5'd0 && ((id_uses_rs1 && id_rs1 == rd) || (id_uses_rs2 && id_rs2 == rd));
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    logic [1:0] r = 2'd0;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs) r = 2'd1;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) r = 2'd2;
    if (!FWD) r = 2'd0;
    return r;
  endfunction

  function automatic bit model_hz();
    if (FWD) return ex_mem_read && src_match(ex_rd, ex_reg_write);
    return src_match(ex_rd, ex_reg_write) || src_match(mem_rd, mem_reg_write) ||
           src_match(wb_rd, wb_reg_write);
  endfunction

  bit   m_br, m_hz, m_stl, m_bub;
  obs_t m_exp, m_cur;

  always @(negedge CLK) begin
    m_br = branch_taken_mem;
    m_hz = model_hz();
    for (int i = 0; i < 2; i++) begin
      m_stl = left[i] > 0;
      m_bub = !m_br && (m_stl || (!fl[i] && m_hz));
      m_exp = {m_bub, m_bub, m_br, m_bub | m_br, m_br, m_stl | fl[i],
               fwd(ex_rs1), fwd(ex_rs2), 16'(sc[i]), 16'(fc[i])};
      m_cur = (i == 0) ? obs0 : obs1;
      if (chk_en) begin
        total++;
        if (m_cur !== m_exp) begin
          bad++;
          $display("FAIL cycle_model dut%0d t=%0t got=%h want=%h", i, $time, m_cur, m_exp);
        end
      end
      if (!RESET_N) begin
        nleft[i] = 0; nfl[i] = 0; nsc[i] = 0; nfc[i] = 0;
      end else begin
        nfl[i]   = m_br;
        nleft[i] = m_br ? 0 : m_stl ? left[i] - 1 : (m_bub && FWD) ? lat[i] - 1 : 0;
        nsc[i]   = (m_bub && sc[i] < cmax[i]) ? sc[i] + 1 : sc[i];
        nfc[i]   = (m_br && fc[i] < cmax[i]) ? fc[i] + 1 : fc[i];
      end
    end
  end

  always @(posedge CLK) begin
    left = nleft; fl = nfl; sc = nsc; fc = nfc;
  end

  task automatic lit(input string nm, input logic [15:0] got, input int want);
    total++;
    if (got !== 16'(want)) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic look();
    @(negedge CLK);
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0;
    ex_mem_read = 0; branch_taken_mem = 0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    idle();
    step();
    RESET_N = 1'b1;
  endtask

  // lw x5 in EX, add x6,x5,x7 in ID
  task automatic load_hz();
    idle();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5;
    id_rs1 = 5; id_uses_rs1 = 1; id_rs2 = 7; id_uses_rs2 = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    RESET_N = 1'b0;
    idle();
    do_reset();
    chk_en = 1'b1;
    look();
    lit("rst_pc_hold_d1", pc_hold_0, 0);
    lit("rst_busy_d3", busy_1, 0);
    lit("rst_stall_d3", sc_1, 0);

    // Load-use with latency 1 and 3, then forward from WB
    step(); load_hz();
    look();
    lit("lu_pc_hold_d1", pc_hold_0, 1);
    lit("lu_if_id_hold_d1", if_id_hold_0, 1);
    lit("lu_id_ex_clear_d1", id_ex_clear_0, 1);
    lit("lu_busy_d3", busy_1, 0);
    step(); idle(); ex_rs1 = 5; ex_rs2 = 7; wb_rd = 5; wb_reg_write = 1;
    look();
    lit("lu_stall_d1", sc_0, 1);
    lit("lu_fwd_a_wb_d1", fa_0, FWD ? 2 : 0);
    lit("lu_pc_hold_c1_d1", pc_hold_0, 0);
    lit("lu_pc_hold_c1_d3", pc_hold_1, FWD ? 1 : 0);
    lit("lu_busy_c1_d3", busy_1, FWD ? 1 : 0);
    step();
    look();
    lit("lu_pc_hold_c2_d3", pc_hold_1, FWD ? 1 : 0);
    lit("lu_stall_c2_d3", sc_1, FWD ? 2 : 1);
    step();
    look();
    lit("lu_pc_hold_c3_d3", pc_hold_1, 0);
    lit("lu_busy_c3_d3", busy_1, 0);
    lit("lu_stall_c3_d3", sc_1, FWD ? 3 : 1);
    lit("lu_stall_c3_d1", sc_0, 1);

    // Forwarding priority and x0
    step(); idle(); mem_rd = 4; wb_rd = 4; mem_reg_write = 1; wb_reg_write = 1; ex_rs1 = 4;
    look();
    lit("fwd_mem_prio", fa_0, FWD ? 1 : 0);
    step(); mem_rd = 3; ex_rs1 = 3; ex_rs2 = 4;
    look();
    lit("fwd_b_wb", fb_0, FWD ? 2 : 0);
    lit("fwd_a_mem", fa_0, FWD ? 1 : 0);
    step(); idle(); mem_reg_write = 1; wb_reg_write = 1;
    look();
    lit("fwd_x0", fa_0, 0);

    // Branch during stall, hz suppressed in FLUSH, back-to-back branches
    do_reset(); load_hz();
    look();
    lit("br_pc_hold_c0_d3", pc_hold_1, 1);
    step();
    look();
    lit("br_stall_c1_d3", sc_1, 1);
    step(); branch_taken_mem = 1;
    look();
    lit("br_if_id_clear", if_id_clear_1, 1);
    lit("br_id_ex_clear", id_ex_clear_1, 1);
    lit("br_ex_mem_clear", ex_mem_clear_1, 1);
    lit("br_pc_hold", pc_hold_1, 0);
    lit("br_if_id_hold", if_id_hold_1, 0);
    lit("br_busy_stall", busy_1, FWD ? 1 : 0);
    step(); branch_taken_mem = 0;
    look();
    lit("fl_busy_d3", busy_1, 1);
    lit("fl_hz_suppressed_d3", pc_hold_1, 0);
    lit("fl_hz_suppressed_d1", pc_hold_0, 0);
    lit("fl_flush_d3", fc_1, 1);
    lit("fl_stall_d3", sc_1, 2);
    step();
    look();
    lit("run_busy_d3", busy_1, 0);
    lit("run_pc_hold_d3", pc_hold_1, 1);
    step(); idle(); branch_taken_mem = 1;
    look();
    lit("b2b_first_clear", ex_mem_clear_1, 1);
    step();
    look();
    lit("b2b_busy", busy_1, 1);
    lit("b2b_clear", ex_mem_clear_1, 1);
    lit("b2b_flush_c1", fc_1, 2);
    step(); branch_taken_mem = 0;
    look();
    lit("b2b_flush_d3", fc_1, 3);
    lit("b2b_flush_d1", fc_0, 3);
    step();
    look();
    lit("b2b_busy_end", busy_1, 0);

    // Reset mid-stall, then flush counter saturation
    do_reset(); load_hz();
    look();
    step(); idle(); RESET_N = 0;
    look();
    lit("rs_busy_before", busy_1, FWD ? 1 : 0);
    step(); RESET_N = 1;
    look();
    lit("rs_busy_after", busy_1, 0);
    lit("rs_pc_hold_after", pc_hold_1, 0);
    lit("rs_stall_d3", sc_1, 0);
    lit("rs_stall_d1", sc_0, 0);
    step(); branch_taken_mem = 1;
    repeat (19) step();
    step(); branch_taken_mem = 0;
    look();
    lit("sat_flush_d3", fc_1, 15);
    lit("sat_flush_d1", fc_0, 20);
    step(); branch_taken_mem = 1;
    step(); branch_taken_mem = 0;
    look();
    lit("sat_hold_d3", fc_1, 15);
    lit("sat_more_d1", fc_0, 21);

    // add x3 ; add x4,x3,x3 back-to-back
    do_reset(); ex_rd = 3; ex_reg_write = 1; id_rs1 = 3; id_rs2 = 3; id_uses_rs1 = 1; id_uses_rs2 = 1;
    look();
    lit("raw_ex_stall", pc_hold_0, FWD ? 0 : 1);
    step(); ex_reg_write = 0; ex_rd = 0; mem_rd = 3; mem_reg_write = 1; ex_rs1 = 3;
    look();
    lit("raw_mem_stall", pc_hold_0, FWD ? 0 : 1);
    lit("raw_mem_fwd", fa_0, FWD ? 1 : 0);
    step(); mem_reg_write = 0; mem_rd = 0; wb_rd = 3; wb_reg_write = 1; ex_rs1 = 0;
    look();
    lit("raw_wb_stall", pc_hold_0, FWD ? 0 : 1);
    step(); idle();
    look();
    lit("raw_done", pc_hold_0, 0);
    lit("raw_stall_count", sc_0, FWD ? 0 : 3);
    lit("raw_fwd_b", fb_0, 0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
